// File: rtl/systolic_array_ctrl_pkg.sv
// Shared array-geometry macros, FSM state encoding and default parameters for the systolic array sequencer.
// Pure definitions; no logic, no latency, no flow control.
`ifndef SYSTOLIC_ARRAY_DEFINES
`define SYSTOLIC_ARRAY_DEFINES
`define DATASIZE            8
`define ARRAYWIDTH          4
`define ARRAYHEIGHT         4
`define OUTPUT_BUF_DATASIZE 32
`define SA_OUT_LAT          `ARRAYHEIGHT
`define SA_ST_IDLE          2'd0
`define SA_ST_LOAD_W        2'd1
`define SA_ST_STREAM        2'd2
`define SA_ST_DRAIN         2'd3
`endif

package systolic_array_ctrl_pkg;

    localparam int DEF_H  = `ARRAYHEIGHT;
    localparam int DEF_W  = `ARRAYWIDTH;
    localparam int DEF_DW = `DATASIZE;
    localparam int DEF_OW = `OUTPUT_BUF_DATASIZE;

    typedef enum logic [1:0] {
        ST_IDLE   = `SA_ST_IDLE,
        ST_LOAD_W = `SA_ST_LOAD_W,
        ST_STREAM = `SA_ST_STREAM,
        ST_DRAIN  = `SA_ST_DRAIN
    } state_t;

endpackage

// File: rtl/systolic_array_ctrl_skew_buffer.sv
// Triangular delay line: lane i delayed by i cycles, or by LANES-1-i when REVERSE is set.
// Lanes with zero delay are pure wires; no flow control, cleared by reset.
module skew_buffer #(
    parameter int LANES   = 4,
    parameter int LW      = 8,
    parameter bit REVERSE = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [LANES*LW-1:0]   din,
    output logic [LANES*LW-1:0]   dout
);

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        localparam int D = REVERSE ? (LANES - 1 - i) : i;
        if (D == 0) begin : g_wire
            assign dout[i*LW +: LW] = din[i*LW +: LW];
        end else begin : g_dly
            logic [LW-1:0] sr [D];
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    for (int k = 0; k < D; k++) sr[k] <= '0;
                end else begin
                    sr[0] <= din[i*LW +: LW];
                    for (int k = 1; k < D; k++) sr[k] <= sr[k-1];
                end
            end
            assign dout[i*LW +: LW] = sr[D-1];
        end
    end

endmodule

// File: rtl/systolic_array_ctrl.sv
// Sequencer: loads one weight tile, streams M skewed activation vectors, de-skews and writes M results.
// Fixed pipeline latency of H+3+M+OUT_LAT+W cycles from start to done; no backpressure from buffers.
module systolic_array_ctrl
    import systolic_array_ctrl_pkg::*;
#(
    parameter int H       = DEF_H,
    parameter int W       = DEF_W,
    parameter int DW      = DEF_DW,
    parameter int OW      = DEF_OW,
    parameter int AW      = 8,
    parameter int OUT_LAT = H
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [AW-1:0]     cfg_num_vec,
    output logic              busy,
    output logic              done,
    output logic              wbuf_rd_en,
    output logic [AW-1:0]     wbuf_rd_addr,
    input  logic [DW*W-1:0]   wbuf_rd_data,
    output logic              abuf_rd_en,
    output logic [AW-1:0]     abuf_rd_addr,
    input  logic [DW*H-1:0]   abuf_rd_data,
    output logic              write_weight_en,
    output logic [DW*W-1:0]   in_up_weight,
    output logic [DW*H-1:0]   in_left_act,
    input  logic [W*OW-1:0]   out_sum,
    output logic              obuf_wr_en,
    output logic [AW-1:0]     obuf_wr_addr,
    output logic [W*OW-1:0]   obuf_wr_data
);

    localparam int            PL       = OUT_LAT + W;
    localparam logic [AW-1:0] LOAD_END = AW'(H);
    localparam logic [AW-1:0] ONE      = AW'(1);

    state_t          state, state_nxt;
    logic [AW-1:0]   cnt, cnt_nxt;
    logic [AW-1:0]   num_vec;
    logic [AW-1:0]   wr_addr;
    logic            accept;
    logic            drain_go;
    logic [PL:0]     vld_pipe;
    logic [PL+1:0]   end_pipe;
    logic [DW*H-1:0] act_in;
    logic [W*OW-1:0] deskew;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        accept    = 1'b0;
        drain_go  = 1'b0;
        case (state)
            ST_IDLE: begin
                // done is high in the first IDLE cycle; a new job waits one more cycle
                if (start && !done) begin
                    accept    = 1'b1;
                    state_nxt = ST_LOAD_W;
                    cnt_nxt   = '0;
                end
            end
            ST_LOAD_W: begin
                if (cnt == LOAD_END) begin
                    cnt_nxt = '0;
                    if (num_vec == '0) begin
                        state_nxt = ST_DRAIN;
                        drain_go  = 1'b1;
                    end else begin
                        state_nxt = ST_STREAM;
                    end
                end else begin
                    cnt_nxt = cnt + ONE;
                end
            end
            ST_STREAM: begin
                if (cnt == num_vec - ONE) begin
                    state_nxt = ST_DRAIN;
                    drain_go  = 1'b1;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + ONE;
                end
            end
            ST_DRAIN: begin
                if (end_pipe[PL]) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state           <= ST_IDLE;
            cnt             <= '0;
            num_vec         <= '0;
            wr_addr         <= '0;
            write_weight_en <= 1'b0;
            vld_pipe        <= '0;
            end_pipe        <= '0;
            obuf_wr_data    <= '0;
        end else begin
            state           <= state_nxt;
            cnt             <= cnt_nxt;
            write_weight_en <= wbuf_rd_en;
            // end_pipe carries a job-end marker through the same depth as the result tags
            vld_pipe        <= {vld_pipe[PL-1:0], abuf_rd_en};
            end_pipe        <= {end_pipe[PL:0], drain_go};
            obuf_wr_data    <= deskew;
            if (accept) num_vec <= cfg_num_vec;
            if (accept)          wr_addr <= '0;
            else if (obuf_wr_en) wr_addr <= wr_addr + ONE;
        end
    end

    assign busy         = (state != ST_IDLE);
    assign done         = end_pipe[PL+1];
    assign wbuf_rd_en   = (state == ST_LOAD_W) && (cnt != LOAD_END);
    assign wbuf_rd_addr = wbuf_rd_en ? cnt : '0;
    assign abuf_rd_en   = (state == ST_STREAM);
    assign abuf_rd_addr = abuf_rd_en ? cnt : '0;
    assign in_up_weight = write_weight_en ? wbuf_rd_data : '0;
    assign act_in       = vld_pipe[0] ? abuf_rd_data : '0;
    assign obuf_wr_en   = vld_pipe[PL];
    assign obuf_wr_addr = obuf_wr_en ? wr_addr : '0;

    skew_buffer #(.LANES(H), .LW(DW), .REVERSE(1'b0)) u_in_skew (
        .clk  (clk),
        .rst  (rst),
        .din  (act_in),
        .dout (in_left_act)
    );

    skew_buffer #(.LANES(W), .LW(OW), .REVERSE(1'b1)) u_out_deskew (
        .clk  (clk),
        .rst  (rst),
        .din  (out_sum),
        .dout (deskew)
    );

endmodule

// File: doc/systolic_array_ctrl.md
# systolic_array_ctrl

Sequencer for the weight-stationary `systolic_array`. On a `start` command it loads one weight tile from the weight buffer, then streams `cfg_num_vec` activation vectors from the activation buffer into the array with per-row skew. It de-skews the column results and writes one aligned result word per vector to the output buffer. It sits between the three on-chip buffers and the array, and pulses `done` when the last result is written.

## Interface
Parameters:
- `H`, default `` `ARRAYHEIGHT ``: array rows.
- `W`, default `` `ARRAYWIDTH ``: array columns.
- `DW`, default `` `DATASIZE ``: weight/activation element width.
- `OW`, default `` `OUTPUT_BUF_DATASIZE ``: psum element width.
- `AW`, default 8: buffer address width.
- `OUT_LAT`, default `H`: cycles from a vector's row-0 element on `in_left_act` to its column-0 result on `out_sum`.

Ports:
- `clk` in 1: clock; all logic on the rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `start` in 1: command strobe; sampled only in IDLE.
- `cfg_num_vec` in AW: number of activation vectors M; latched with `start`.
- `busy` out 1: high from the cycle after `start` is accepted until `done`.
- `done` out 1: one-cycle pulse at job end.
- `wbuf_rd_en` out 1, `wbuf_rd_addr` out AW, `wbuf_rd_data` in DW*W: weight buffer read port; data is valid 1 cycle after `rd_en`.
- `abuf_rd_en` out 1, `abuf_rd_addr` out AW, `abuf_rd_data` in DW*H: activation buffer read port; element i is for row i; latency 1.
- `write_weight_en` out 1, `in_up_weight` out DW*W: array weight load.
- `in_left_act` out DW*H: skewed activations, one element per row.
- `out_sum` in W*OW: array bottom-row psums.
- `obuf_wr_en` out 1, `obuf_wr_addr` out AW, `obuf_wr_data` out W*OW: output buffer write port.

## Operation
- State machine IDLE → LOAD_W → STREAM → DRAIN → IDLE.
- IDLE: when `start`=1, latch M and go to LOAD_W. `start` in any other state is ignored.
- LOAD_W: H cycles with `wbuf_rd_en`=1 and addresses 0..H-1. One cycle later, `write_weight_en`=1 for H cycles with `in_up_weight`=`wbuf_rd_data`. Word k is pushed k-th, so word 0 lands in row H-1. The next state is STREAM if M>0, otherwise DRAIN.
- STREAM: M cycles with `abuf_rd_en`=1 and addresses 0..M-1. Returned vector j enters the input skew line: row i element appears on `in_left_act` i cycles after row 0. Skew lanes carry zeros whenever no vector is valid.
- DRAIN: wait until M result words have been written.
- Output de-skew: column c of `out_sum` is delayed by W-1-c cycles and then registered once, producing aligned `obuf_wr_data`.
- A valid-tag pipeline follows each vector, so `obuf_wr_en` is high exactly M times, with `obuf_wr_addr` = j for vector j.
- `done` pulses the cycle after the last write; `busy` falls in the same cycle. With M=0, `done` follows LOAD_W with no abuf reads and no obuf writes.
- Arithmetic: results pass through unmodified, no truncation. Address counters are AW bits; M ≤ 2^AW − 1.
- Reset while active (`rst` low in any state):
  - return to IDLE;
  - clear all skew and de-skew registers and valid tags;
  - abandon the in-flight job with no `done` pulse.

## Timing
- Reset values: all outputs are 0, including `busy`, `done`, the enables, addresses, `in_left_act`, `in_up_weight` and `obuf_wr_data`.
- With `start` sampled at cycle T:
  - `wbuf_rd_en` is high at T+1..T+H.
  - `write_weight_en` is high at T+2..T+H+1.
  - `abuf_rd_en` is high at T+H+2..T+H+1+M.
  - Row-0 element of vector j is on `in_left_act` at T+H+3+j; row i at T+H+3+j+i.
  - `obuf_wr_en` for vector j is at T+H+3+j+OUT_LAT+W.
  - `done` is at T+H+3+M+OUT_LAT+W.
- Streaming is back-to-back with no bubbles.
- A new `start` is accepted in the cycle after `done`.

## Structure
- Shared defines header holds the state encoding and the default `OUT_LAT`, alongside the existing `DATASIZE`, `ARRAYWIDTH`, `ARRAYHEIGHT` and `OUTPUT_BUF_DATASIZE` macros.
- One sub-module, `skew_buffer`: a parameterised triangular delay line with lane widths and per-lane delays set by parameters, clearable on reset. It is instantiated twice: input skew (lane i delay i) and output de-skew (lane c delay W-1-c).

## Test plan
Common settings: H=W=4, OUT_LAT=4, start at T=0.
- Basic job, M=3: wbuf reads at 1..4, `write_weight_en` at 2..5, abuf reads at 6..8, row-0 acts at 7..9, row-3 acts at 10..12, obuf writes to addresses 0,1,2 at 15..17, `done` at 18.
- Identity weights, activation vector (1,2,3,4): `obuf_wr_data` column c = element c. Columns are aligned in a single write.
- M=0: `done` at 15; no `abuf_rd_en` or `obuf_wr_en` ever asserted.
- `start` held high through the whole job: exactly one job runs; the next job starts only when `start` is sampled in IDLE after `done`.
- `rst` low at cycle 8: all outputs read 0 next sample and no `done` pulse. A fresh M=1 job then produces exactly one obuf write with zero-cleared skew history.
